// File: rtl/uart_mem_master.sv
// Host-side initiator for the UART byte memory-access protocol: turns single
// read/write requests into command bytes and returns the read response byte.
module uart_mem_master #(
   parameter int AddrWidth     = 7,
   parameter int DataSize      = 8,
   parameter int TimeoutCycles = 1562500
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic                 i_req_write,
   input  logic [AddrWidth-1:0] i_req_addr,
   input  logic [DataSize-1:0]  i_req_wdata,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [DataSize-1:0]  o_rsp_rdata,
   output logic                 o_rsp_error,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic [DataSize-1:0]  o_tx_data,
   input  logic                 i_rx_valid,
   output logic                 o_rx_ready,
   input  logic [DataSize-1:0]  i_rx_data,
   output logic                 o_busy,
   output logic                 o_stray
);

   localparam int CntW = $clog2(TimeoutCycles);

   typedef enum logic [2:0] {
      IDLE,
      SEND_CMD,
      SEND_DATA,
      WAIT_RSP,
      RSP_OUT
   } state_t;

   state_t              state;
   logic                req_write;
   logic [DataSize-1:0] req_wdata;
   logic [CntW-1:0]     cnt;

   // All outputs are registered; each transition sets the outputs of the state it enters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_req_ready <= 1'b1;
         o_rx_ready  <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_error <= 1'b0;
         o_tx_valid  <= 1'b0;
         o_tx_data   <= '0;
         o_busy      <= 1'b0;
         o_stray     <= 1'b0;
         req_write   <= 1'b0;
         req_wdata   <= '0;
         cnt         <= '0;
      end else begin
         o_stray <= 1'b0;
         case (state)
            IDLE: begin
               if (i_rx_valid && o_rx_ready) o_stray <= 1'b1;
               if (i_req_valid && o_req_ready) begin
                  req_write   <= i_req_write;
                  req_wdata   <= i_req_wdata;
                  o_tx_valid  <= 1'b1;
                  o_tx_data   <= {i_req_write, i_req_addr};
                  o_req_ready <= 1'b0;
                  o_rx_ready  <= 1'b0;
                  o_busy      <= 1'b1;
                  state       <= SEND_CMD;
               end
            end
            SEND_CMD: begin
               if (i_tx_ready) begin
                  if (req_write) begin
                     o_tx_data <= req_wdata;
                     state     <= SEND_DATA;
                  end else begin
                     o_tx_valid <= 1'b0;
                     o_rx_ready <= 1'b1;
                     cnt        <= '0;
                     state      <= WAIT_RSP;
                  end
               end
            end
            SEND_DATA: begin
               if (i_tx_ready) begin
                  o_tx_valid  <= 1'b0;
                  o_req_ready <= 1'b1;
                  o_rx_ready  <= 1'b1;
                  o_busy      <= 1'b0;
                  state       <= IDLE;
               end
            end
            WAIT_RSP: begin
               // A byte arriving on the final counted cycle takes priority over the timeout.
               if (i_rx_valid) begin
                  o_rsp_rdata <= i_rx_data;
                  o_rsp_error <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  o_rx_ready  <= 1'b0;
                  state       <= RSP_OUT;
               end else if (cnt == CntW'(TimeoutCycles - 1)) begin
                  o_rsp_rdata <= '0;
                  o_rsp_error <= 1'b1;
                  o_rsp_valid <= 1'b1;
                  o_rx_ready  <= 1'b0;
                  state       <= RSP_OUT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RSP_OUT: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_req_ready <= 1'b1;
                  o_rx_ready  <= 1'b1;
                  o_busy      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               o_tx_valid  <= 1'b0;
               o_rsp_valid <= 1'b0;
               o_req_ready <= 1'b1;
               o_rx_ready  <= 1'b1;
               o_busy      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
